// File: rtl/sevenseg_scan_driver.sv
// Multiplexed N-digit seven-segment scan driver with per-frame input snapshot and anode dead time.
// Optional leading-zero blanking is enabled by defining SEVSEG_LZB_EN.
module sevenseg_scan_driver #(
  parameter int N_DIGITS       = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int DEAD_CYCLES    = 2,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [4*N_DIGITS-1:0] i_value,
  input  logic [N_DIGITS-1:0]   i_digit_en,
  input  logic [N_DIGITS-1:0]   i_dp,
  input  logic                  i_state_mode,
  input  logic [2:0]            i_debug_state,
  output logic [6:0]            o_seg,
  output logic                  o_dp,
  output logic [N_DIGITS-1:0]   o_anode,
  output logic                  o_frame
);

  localparam int PCW  = $clog2(REFRESH_DIV);
  localparam int IDXW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PCW-1:0]  PC_LAST  = PCW'(REFRESH_DIV - 1);
  localparam logic [PCW-1:0]  PC_DEAD  = PCW'(DEAD_CYCLES);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [6:0]          SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                DP_OFF  = (SEG_ACTIVE_LOW != 0);

  typedef enum logic {ST_START, ST_SCAN} state_t;

  state_t                state_q;
  logic [PCW-1:0]        pc_q;
  logic [IDXW-1:0]       idx_q;
  logic [4*N_DIGITS-1:0] shValue_q;
  logic [N_DIGITS-1:0]   shDigitEn_q;
  logic [N_DIGITS-1:0]   shDp_q;
  logic                  shStateMode_q;
  logic [2:0]            shDebugState_q;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [N_DIGITS-1:0]   anode_q, anode_d;
  logic                  frame_q;

  logic [N_DIGITS-1:0] blank;
  logic [3:0]          nibble;
  logic [6:0]          glyph;
  logic                glyphDp;
  logic                digitOn;
  logic                isStateDigit;

  function automatic logic [6:0] hexGlyph(input logic [3:0] n);
    case (n)
      4'h0: hexGlyph = 7'h3F;  4'h1: hexGlyph = 7'h06;
      4'h2: hexGlyph = 7'h5B;  4'h3: hexGlyph = 7'h4F;
      4'h4: hexGlyph = 7'h66;  4'h5: hexGlyph = 7'h6D;
      4'h6: hexGlyph = 7'h7D;  4'h7: hexGlyph = 7'h07;
      4'h8: hexGlyph = 7'h7F;  4'h9: hexGlyph = 7'h6F;
      4'hA: hexGlyph = 7'h77;  4'hB: hexGlyph = 7'h7C;
      4'hC: hexGlyph = 7'h39;  4'hD: hexGlyph = 7'h5E;
      4'hE: hexGlyph = 7'h79;  default: hexGlyph = 7'h71;
    endcase
  endfunction

  // Odd codes are the START_* family and all share the 'P' glyph.
  function automatic logic [6:0] stateGlyph(input logic [2:0] s);
    case (s)
      3'd0:    stateGlyph = 7'h40;
      3'd2:    stateGlyph = 7'h38;
      3'd4:    stateGlyph = 7'h50;
      3'd6:    stateGlyph = 7'h6D;
      3'd7:    stateGlyph = 7'h00;
      default: stateGlyph = 7'h73;
    endcase
  endfunction

`ifdef SEVSEG_LZB_EN
  // Walk down from the top digit; a digit is blanked while everything at or above it is zero.
  always_comb begin
    logic allZero;
    blank   = '0;
    allZero = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      allZero  = allZero && (shValue_q[4*k +: 4] == 4'h0);
      blank[k] = allZero && (k != 0);
    end
    if (shStateMode_q) blank[N_DIGITS-1] = 1'b0;
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    isStateDigit = shStateMode_q && (idx_q == IDX_LAST);
    nibble       = shValue_q[4*int'(idx_q) +: 4];
    glyph        = isStateDigit ? stateGlyph(shDebugState_q) : hexGlyph(nibble);
    glyphDp      = isStateDigit ? 1'b0 : shDp_q[idx_q];
    digitOn      = (pc_q >= PC_DEAD) && shDigitEn_q[idx_q] && !blank[idx_q];
    anode_d      = digitOn ? (N_DIGITS'(1) << idx_q) : '0;
    seg_d        = digitOn ? glyph : 7'h00;
    dp_d         = digitOn && glyphDp;
    if (AN_ACTIVE_LOW != 0) anode_d = ~anode_d;
    if (SEG_ACTIVE_LOW != 0) begin
      seg_d = ~seg_d;
      dp_d  = ~dp_d;
    end
  end

  // ST_START takes the post-reset snapshot while holding the scan at digit 0,
  // so the state afterwards matches the one following a normal frame wrap.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q        <= ST_START;
      pc_q           <= '0;
      idx_q          <= '0;
      shValue_q      <= '0;
      shDigitEn_q    <= '0;
      shDp_q         <= '0;
      shStateMode_q  <= 1'b0;
      shDebugState_q <= 3'd0;
      seg_q          <= SEG_OFF;
      dp_q           <= DP_OFF;
      anode_q        <= AN_OFF;
      frame_q        <= 1'b0;
    end else begin
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      anode_q <= anode_d;
      frame_q <= 1'b0;
      case (state_q)
        ST_START: begin
          state_q        <= ST_SCAN;
          shValue_q      <= i_value;
          shDigitEn_q    <= i_digit_en;
          shDp_q         <= i_dp;
          shStateMode_q  <= i_state_mode;
          shDebugState_q <= i_debug_state;
          frame_q        <= 1'b1;
        end
        default: begin
          if (pc_q == PC_LAST) begin
            pc_q <= '0;
            if (idx_q == IDX_LAST) begin
              idx_q          <= '0;
              shValue_q      <= i_value;
              shDigitEn_q    <= i_digit_en;
              shDp_q         <= i_dp;
              shStateMode_q  <= i_state_mode;
              shDebugState_q <= i_debug_state;
              frame_q        <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            pc_q <= pc_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign o_seg   = seg_q;
  assign o_dp    = dp_q;
  assign o_anode = anode_q;
  assign o_frame = frame_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver: frame-position reference model checked every cycle.
// Mirrors the SEVSEG_LZB_EN build option in its model.
module tb_sevenseg_scan_driver;

  localparam int N  = 4;
  localparam int R  = 4;
  localparam int D  = 1;
  localparam int FR = N * R;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [15:0] value;
  logic [3:0]  digitEn;
  logic [3:0]  dpIn;
  logic        stateMode;
  logic [2:0]  debugState;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  anode;
  logic        frame;

  sevenseg_scan_driver #(
    .N_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYCLES(D),
    .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
  ) dut (
    .i_clock(clock), .i_reset(reset), .i_value(value), .i_digit_en(digitEn),
    .i_dp(dpIn), .i_state_mode(stateMode), .i_debug_state(debugState),
    .o_seg(seg), .o_dp(dp), .o_anode(anode), .o_frame(frame)
  );

  logic [6:0] hexTab[16];
  logic [6:0] stateTab[8];

  // Model: snapshot plus a single position counter 0..FR-1 within the frame.
  logic [15:0] mValue;
  logic [3:0]  mEn, mDp;
  logic        mSm;
  logic [2:0]  mSt;
  int          pos;
  bit          fresh;
  logic [3:0]  expAnode;
  logic [6:0]  expSeg;
  logic        expDp, expFrame;

  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] v, input logic [3:0] en, input logic [3:0] p,
                               input logic sm, input logic [2:0] st);
    value = v; digitEn = en; dpIn = p; stateMode = sm; debugState = st;
  endtask

  task automatic capture();
    mValue = value; mEn = digitEn; mDp = dpIn; mSm = stateMode; mSt = debugState;
  endtask

  task automatic modelEdge();
    int d, ph;
    bit on, isState;
    logic [3:0] nib;
    logic [6:0] g;
    logic p;
    d  = pos / R;
    ph = pos % R;
    nib = 4'(mValue >> (4 * d));
    isState = mSm && (d == N - 1);
    on = (ph >= D) && mEn[d];
`ifdef SEVSEG_LZB_EN
    if (d > 0 && (mValue >> (4 * d)) == 0 && !isState) on = 0;
`endif
    g = isState ? stateTab[mSt] : hexTab[nib];
    p = isState ? 1'b0 : mDp[d];
    expAnode = on ? ~(4'b0001 << d) : 4'hF;
    expSeg   = on ? g : 7'h00;
    expDp    = on ? p : 1'b0;
    expFrame = 1'b0;
    if (fresh) begin
      capture(); fresh = 0; pos = 0; expFrame = 1'b1;
    end else if (pos == FR - 1) begin
      capture(); pos = 0; expFrame = 1'b1;
    end else begin
      pos++;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    modelEdge();
    #1;
    checkOutput("anode", {4'h0, anode}, {4'h0, expAnode});
    checkOutput("seg",   {1'b0, seg},   {1'b0, expSeg});
    checkOutput("dp",    {7'h0, dp},    {7'h0, expDp});
    checkOutput("frame", {7'h0, frame}, {7'h0, expFrame});
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic runToPos(input int target);
    for (int i = 0; i < 2 * FR; i++) begin
      if (pos == target && !fresh) break;
      tick();
    end
  endtask

  // Reset asserted between edges must blank the outputs immediately.
  task automatic doReset();
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_anode", {4'h0, anode}, 8'h0F);
    checkOutput("rst_seg",   {1'b0, seg},   8'h00);
    checkOutput("rst_frame", {7'h0, frame}, 8'h00);
    mValue = '0; mEn = '0; mDp = '0; mSm = 1'b0; mSt = '0;
    pos = 0; fresh = 1;
    @(posedge clock);
    #1;
    checkOutput("rst_hold_anode", {4'h0, anode}, 8'h0F);
    checkOutput("rst_hold_dp",    {7'h0, dp},    8'h00);
    reset = 1'b0;
  endtask

  initial begin
    logic [2:0] glyphStates[5];
    hexTab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    stateTab = '{7'h40, 7'h73, 7'h38, 7'h73, 7'h50, 7'h73, 7'h6D, 7'h00};
    glyphStates = '{3'd2, 3'd4, 3'd6, 3'd3, 3'd7};
    reset = 1'b1;
    applyStimulus(16'h0000, 4'h0, 4'h0, 1'b0, 3'd0);
    pos = 0; fresh = 1;

    doReset();
    $display("[TB] hex scan");
    applyStimulus(16'h1A2F, 4'hF, 4'h0, 1'b0, 3'd0);
    runCycles(2 * FR + 2);

    $display("[TB] mid-slot reset and snapshot");
    runCycles(5);
    doReset();
    applyStimulus(16'h1234, 4'hF, 4'h0, 1'b0, 3'd0);
    runToPos(R + 1);
    applyStimulus(16'h5678, 4'hF, 4'h0, 1'b0, 3'd0);
    runCycles(2 * FR);

    $display("[TB] state glyphs");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(16'h9ABC, 4'hF, 4'hF, 1'b1, glyphStates[i]);
      runCycles(FR);
    end

    $display("[TB] enable and decimal point");
    applyStimulus(16'h1234, 4'b0101, 4'b0001, 1'b0, 3'd0);
    runCycles(2 * FR);

    $display("[TB] leading zeros");
    applyStimulus(16'h0042, 4'hF, 4'h0, 1'b0, 3'd0);
    runCycles(2 * FR);
    applyStimulus(16'h0000, 4'hF, 4'hF, 1'b0, 3'd0);
    runCycles(2 * FR);
    applyStimulus(16'h0000, 4'hF, 4'h0, 1'b1, 3'd0);
    runCycles(2 * FR);

    $display("[TB] randomized frames");
    for (int i = 0; i < 30; i++) begin
      applyStimulus(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 3'($urandom));
      runCycles($urandom_range(1, 2 * FR));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_driver.md
# sevenseg_scan_driver

Multiplexed N-digit seven-segment display driver for the debug front panel; the parametrised successor of the single-digit debug-state decoder. It time-multiplexes a packed hex value across N_DIGITS common-anode digits and can replace the most significant digit with a debug-state glyph. Inputs are snapshotted once per refresh frame, so the display never tears. Anode dead time between digit slots suppresses ghosting.

## Interface
- N_DIGITS, 4: digit count, 1..8.
- REFRESH_DIV, 50000: clock cycles per digit slot, at least 2.
- DEAD_CYCLES, 2: cycles at the start of each slot with all anodes off, 0..REFRESH_DIV-1.
- SEG_ACTIVE_LOW, 0: 1 inverts o_seg and o_dp at the output register.
- AN_ACTIVE_LOW, 1: 1 makes o_anode active-low.
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_value  in  4*N_DIGITS  packed nibbles; nibble k drives digit k, with digit 0 rightmost.
- i_digit_en  in  N_DIGITS  per-digit enable; a disabled digit keeps its anode off for its whole slot.
- i_dp  in  N_DIGITS  per-digit decimal point.
- i_state_mode  in  1  when 1, digit N_DIGITS-1 shows the glyph for i_debug_state.
- i_debug_state  in  3  debug FSM state code.
- o_seg  out  7  segments; bit0=a through bit6=g.
- o_dp  out  1  decimal point.
- o_anode  out  N_DIGITS  digit select, one-hot when active.
- o_frame  out  1  one-cycle pulse, asserted on the cycle the snapshot is taken.

## Operation
- Prescaler `pc`, width clog2(REFRESH_DIV), counts 0..REFRESH_DIV-1 and wraps to 0.
- Digit index `idx` advances on the terminal count (`pc` = REFRESH_DIV-1). It wraps from N_DIGITS-1 to 0.
- On the `idx` wrap to 0, and on the first cycle after reset release, the block captures i_value, i_digit_en, i_dp, i_state_mode and i_debug_state into shadow registers. o_frame pulses on that same cycle.
- Hex glyphs, active-high, for nibbles 0..F: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F, 77, 7C, 39, 5E, 79, 71.
- State glyphs, used when shadow state_mode = 1 and only on digit N_DIGITS-1. The state's decimal point is forced to 0.
  - 0 (IDLE): '-' 40
  - 2 (WAIT_LOAD): 'L' 38
  - 4 (WAIT_RUN): 'r' 50
  - 6 (WAIT_STEP): 'S' 6D
  - 1, 3, 5 (START_*): 'P' 73
  - 7: blank 00
- Anode for the current digit is active only when all of the following hold:
  - `pc` >= DEAD_CYCLES
  - shadow digit_en[idx] = 1
  - not blanked by LZB (see Configuration)
- o_seg is 00 (polarity applied) whenever the anode is inactive.
- o_seg, o_dp and o_anode are registered. Polarity inversion is applied in the same register.
- Reset (asynchronous, active-high) clears:
  - `pc` = 0, `idx` = 0, shadows = 0
  - o_anode = all inactive (all 1 when AN_ACTIVE_LOW)
  - o_seg and o_dp = off (all 1 when SEG_ACTIVE_LOW)
  - o_frame = 0
- Reset asserted mid-slot aborts the slot immediately. After release, scanning restarts at digit 0 with a fresh snapshot.

## Timing
- Output latency is 1 cycle from (`idx`, `pc`) to o_anode/o_seg.
- Input-to-display latency is at most one full frame: N_DIGITS*REFRESH_DIV cycles plus 1.
- Each digit's anode is active for REFRESH_DIV-DEAD_CYCLES cycles per slot.
- o_frame period is N_DIGITS*REFRESH_DIV cycles.
- Input changes between snapshots have no effect on outputs.
- Simultaneous state_mode change and frame wrap: the new value is captured and takes effect for the whole new frame.
- N_DIGITS = 1: `idx` stays 0 and o_frame pulses every REFRESH_DIV cycles.

## Configuration
- SEVSEG_LZB_EN defined: leading-zero blanking.
  - Digits above the most significant nonzero nibble have their anode held inactive, judged from the shadow value.
  - Digit 0 is never blanked.
  - Digit N_DIGITS-1 is never blanked while shadow state_mode = 1.
- SEVSEG_LZB_EN undefined: all enabled digits are shown, including leading zeros.

## Test plan
Common bench parameters: N_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1, SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=1.

- **Reset:** assert i_reset mid-slot -> o_anode=4'hF, o_seg=00 and o_frame=0 in the same cycle. After release, o_frame pulses once and digit 0 is scanned first.
- **Hex scan:** i_value=16'h1A2F, all digits enabled. Each slot shows 1 cycle of o_anode=F with o_seg=00, then 3 cycles of:
  - digit 0: anode E, seg 71
  - digit 1: anode D, seg 5B
  - digit 2: anode B, seg 77
  - digit 3: anode 7, seg 06
  - o_frame repeats every 16 cycles.
- **Snapshot:** change i_value from 1234 to 5678 during the digit-1 slot -> digits 2 and 3 still show 2 and 1. From the next o_frame onward, digits show 8, 7, 6, 5.
- **State glyph:** i_state_mode=1 with i_debug_state set to 2, 4, 6, 3 and 7 across successive frames -> digit 3 shows 38, 50, 6D, 73 and 00 respectively, with o_dp=0.
- **Enable/dp:** i_digit_en=4'b0101, i_dp=4'b0001 -> the anode stays F during the digit-1 and digit-3 slots. o_dp=1 only during the active part of the digit-0 slot.
- **LZB (macro defined):** i_value=0042 -> digits 2 and 3 are dark. i_value=0000 -> only digit 0 is lit, with seg 3F.
